fir_out_decim: RTL and testbench

Output stage placed directly downstream of the 5-tap FIR filter. It consumes the filter's 22-bit registered output every clock and decimates it by a fixed ratio. Each kept sample is rounded and saturated to 12 bits and buffered in a small first-word-fall-through FIFO. Samples are handed to the consumer over a valid/ready handshake.

---
 rtl/fir_out_decim_if.sv | 24 ++
 rtl/fir_out_decim.sv | 82 ++++++++
 tb/tb_fir_out_decim.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fir_out_decim_if.sv
// fir_out_decim_if: sample input, handshaked output and status bundle of fir_out_decim
interface fir_out_decim_if #(
    parameter int DIN_W      = 22,
    parameter int DOUT_W     = 12,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    logic signed [DIN_W-1:0]  din;
    logic                     din_valid;
    logic signed [DOUT_W-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [LW-1:0]            fifo_level;
    logic                     drop_pulse;
    logic                     sat_flag;
    modport master (
        output din, din_valid, dout_ready,
        input  dout, dout_valid, fifo_level, drop_pulse, sat_flag
    );
    modport slave (
        input  din, din_valid, dout_ready,
        output dout, dout_valid, fifo_level, drop_pulse, sat_flag
    );
endinterface

// File: rtl/fir_out_decim.sv
// fir_out_decim: decimate, round-half-up, optionally saturate (FIR_OUT_SAT_EN) and FIFO-buffer FIR samples
module fir_out_decim #(
    parameter int DIN_W      = 22,
    parameter int DOUT_W     = 12,
    parameter int FRAC_SHIFT = 10,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rst,
    fir_out_decim_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;

    logic [CW-1:0]            dcnt;
    logic signed [DOUT_W-1:0] rnd, s1;
    logic                     s1_v, keep, push, pop, sat, drop, sat_flag;
    logic [AW-1:0]            wp, rp;
    logic [LW-1:0]            level;
    logic signed [DOUT_W-1:0] mem [FIFO_DEPTH];

    // sign-extended add of the half-LSB, then keep the bits above FRAC_SHIFT
    function automatic logic [DOUT_W:0] round_shift(input logic [DIN_W-1:0] d);
        return (DOUT_W+1)'(({d[DIN_W-1], d} + (DIN_W+1)'(2 ** (FRAC_SHIFT - 1))) >> FRAC_SHIFT);
    endfunction

    always_comb begin
        keep = bus.din_valid && dcnt == '0;
        pop  = level != '0 && bus.dout_ready;
        push = s1_v && (level < LW'(FIFO_DEPTH) || pop);
    end

`ifdef FIR_OUT_SAT_EN
    logic [DOUT_W:0] sh;
    logic            ovf;
    always_comb begin
        sh  = round_shift(bus.din);
        ovf = sh[DOUT_W] != sh[DOUT_W-1];
        sat = keep && ovf;
        rnd = ovf ? {sh[DOUT_W], {(DOUT_W-1){~sh[DOUT_W]}}} : sh[DOUT_W-1:0];
    end
`else
    always_comb begin
        sat = 1'b0;
        rnd = DOUT_W'(round_shift(bus.din));
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt     <= '0;
            s1_v     <= 1'b0;
            s1       <= '0;
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            drop     <= 1'b0;
            sat_flag <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (bus.din_valid) dcnt <= dcnt == CW'(DECIM - 1) ? '0 : dcnt + 1'b1;
            s1_v <= keep;
            if (keep) s1 <= rnd;
            if (push) begin
                mem[wp] <= s1;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            level    <= level + LW'(push) - LW'(pop);
            drop     <= s1_v && !push;
            sat_flag <= sat_flag || sat;
        end
    end

    assign bus.dout       = mem[rp];
    assign bus.dout_valid = level != '0;
    assign bus.fifo_level = level;
    assign bus.drop_pulse = drop;
    assign bus.sat_flag   = sat_flag;
endmodule

// File: tb/tb_fir_out_decim.sv
// tb_fir_out_decim: directed checks on three instances (DECIM=2, 1, 3) sharing clock and reset
module tb_fir_out_decim;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

`ifdef FIR_OUT_SAT_EN
    localparam int SATV = 2047;
    localparam int SF   = 1;
`else
    localparam int SATV = -2048;
    localparam int SF   = 0;
`endif

    always #5 clk = ~clk;

    fir_out_decim_if b2 ();
    fir_out_decim_if b1 ();
    fir_out_decim_if b3 ();
    fir_out_decim #(.DECIM(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    fir_out_decim #(.DECIM(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    fir_out_decim #(.DECIM(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put2(input int v, input int e, input string tag);
        b2.din = v;
        tick;
        tick;
        chk({tag, "_valid"}, b2.dout_valid, 1);
        chk(tag, $signed(b2.dout), e);
    endtask

    initial begin
        {b2.din, b2.din_valid, b2.dout_ready} = '0;
        {b1.din, b1.din_valid, b1.dout_ready} = '0;
        {b3.din, b3.din_valid, b3.dout_ready} = '0;
        tick;
        tick;
        chk("rst_valid", b2.dout_valid, 0);
        chk("rst_dout", $signed(b2.dout), 0);
        chk("rst_level", b2.fifo_level, 0);
        chk("rst_drop", b2.drop_pulse, 0);
        chk("rst_sat", b2.sat_flag, 0);
        rst = 1'b0;

        // DECIM=2 steady stream: output every other cycle, 2 cycles after first sample
        b2.din = 1536;
        b2.din_valid = 1'b1;
        b2.dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("alt_valid", b2.dout_valid, i % 2);
            if (i % 2 == 1) chk("alt_dout", $signed(b2.dout), 2);
        end
        put2(-1536, -1, "neg1536");
        put2(511, 0, "r511");
        put2(512, 1, "r512");
        put2(2097151, SATV, "posmax");
        chk("sat_set", b2.sat_flag, SF);
        put2(-2097152, -2048, "negmax");
        chk("sat_hold1", b2.sat_flag, SF);
        put2(512, 1, "after_sat");
        chk("sat_hold2", b2.sat_flag, SF);
        b2.din_valid = 1'b0;
        tick;
        tick;
        chk("a_empty", b2.dout_valid, 0);

        // DECIM=1 overflow: 10 samples into a stalled FIFO
        b1.din_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            b1.din = i * 1024;
            tick;
            if (i == 9) chk("full_level", b1.fifo_level, 8);
            if (i == 9) chk("no_drop_yet", b1.drop_pulse, 0);
            if (i == 10) chk("drop9", b1.drop_pulse, 1);
        end
        b1.din_valid = 1'b0;
        tick;
        chk("drop10", b1.drop_pulse, 1);
        chk("full_level2", b1.fifo_level, 8);
        tick;
        chk("drop_end", b1.drop_pulse, 0);
        b1.dout_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_valid", b1.dout_valid, 1);
            chk("drain_dout", $signed(b1.dout), k);
            tick;
        end
        chk("drain_empty", b1.dout_valid, 0);
        chk("drain_level", b1.fifo_level, 0);

        // full FIFO with simultaneous push and pop, across pointer wrap
        b1.dout_ready = 1'b0;
        b1.din_valid = 1'b1;
        for (int v = 11; v <= 19; v++) begin
            b1.din = v * 1024;
            tick;
        end
        chk("wrap_full", b1.fifo_level, 8);
        b1.dout_ready = 1'b1;
        for (int v = 20; v <= 21; v++) begin
            b1.din = v * 1024;
            tick;
            chk("pp_level", b1.fifo_level, 8);
            chk("pp_drop", b1.drop_pulse, 0);
        end
        b1.din_valid = 1'b0;
        tick;
        chk("pp_level_last", b1.fifo_level, 8);
        for (int k = 14; k <= 21; k++) begin
            chk("wrap_dout", $signed(b1.dout), k);
            tick;
        end
        chk("wrap_empty", b1.dout_valid, 0);

        // reset with level 5 and s1 occupied; u2 left with dcnt=1
        b1.dout_ready = 1'b0;
        b1.din_valid = 1'b1;
        b2.din = 0;
        b2.din_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            b1.din = i * 1024;
            tick;
            b2.din_valid = 1'b0;
        end
        chk("pre_rst_level", b1.fifo_level, 5);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        b1.din_valid = 1'b0;
        chk("mrst_level", b1.fifo_level, 0);
        chk("mrst_valid", b1.dout_valid, 0);
        chk("mrst_sat", b2.sat_flag, 0);
        tick;
        chk("mrst_s1_gone", b1.fifo_level, 0);
        b2.din = 3072;
        b2.din_valid = 1'b1;
        tick;
        b2.din_valid = 1'b0;
        tick;
        chk("first_kept_valid", b2.dout_valid, 1);
        chk("first_kept_dout", $signed(b2.dout), 3);

        // DECIM=1 full throughput
        b1.dout_ready = 1'b1;
        b1.din_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            b1.din = (30 + i) * 1024;
            tick;
            if (i > 1) chk("thru_valid", b1.dout_valid, 1);
            if (i > 1) chk("thru_dout", $signed(b1.dout), 30 + i - 1);
        end
        b1.din_valid = 1'b0;

        // DECIM=3 with din_valid toggling: keep valid samples 0,3,6
        b3.dout_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            b3.din = (n + 1) * 1024;
            b3.din_valid = 1'b1;
            tick;
            b3.din_valid = 1'b0;
            tick;
            chk("d3_valid", b3.dout_valid, (n % 3 == 0) ? 1 : 0);
            if (n % 3 == 0) chk("d3_dout", $signed(b3.dout), n + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
